last_block_packer: RTL and testbench

Parametrised byte-stream packer in front of the AES datapath. Accumulates LANE_BYTES-wide input beats into BLOCK_BYTES-wide blocks, generates the per-byte valid mask and byte count for every block, and pads the final block of each message (zero fill or PKCS#7, including the extra full pad block). It is the sequential successor to the combinational last-block mask generator; downstream engines consume `out_data`, `out_mask` and `out_count` directly.

---
 rtl/last_block_packer.sv | 107 ++++++++++
 tb/tb_last_block_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/last_block_packer.sv
// last_block_packer: packs LANE_BYTES-wide beats into BLOCK_BYTES-wide blocks with a byte mask, a byte count
// and zero or PKCS#7 padding of each message's final block, including the extra full pad block.
module last_block_packer #(
    parameter  int BLOCK_BYTES = 16,
    parameter  int LANE_BYTES  = 4,
    localparam int NW          = $clog2(LANE_BYTES + 1),
    localparam int CW          = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*LANE_BYTES-1:0]  in_data,
    input  logic [NW-1:0]            in_nbytes,
    input  logic                     in_last,
    input  logic                     pad_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*BLOCK_BYTES-1:0] out_data,
    output logic [BLOCK_BYTES-1:0]   out_mask,
    output logic [CW-1:0]            out_count,
    output logic                     out_last
);
    typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            fill_q, fill_d, count_q, count_d, cnt;
    logic                     pend_q, pend_d, last_q, last_d;
    logic [8*BLOCK_BYTES-1:0] data_q, data_d, blk;
    logic [BLOCK_BYTES-1:0]   mask_q, mask_d, msk;
    logic [7:0]               acc_q [BLOCK_BYTES];
    logic [7:0]               merged [BLOCK_BYTES];
    logic [NW-1:0]            nb;
    logic [7:0]               pad;
    logic                     fire, done, pkcs_full, padblk_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == FILL ? (done ? HOLD : FILL)
                : !out_ready ? state_q
                : (state_q == HOLD && pend_q) ? PADBLK : FILL;
    end

    always_comb begin
        in_ready  = state_q == FILL;
        out_valid = state_q != FILL;
    end

    // Short beats mid-message count as full lanes; empty ones are dropped without moving fill.
    always_comb begin
        nb          = in_last ? (in_nbytes > NW'(LANE_BYTES) ? NW'(LANE_BYTES) : in_nbytes)
                    : (in_nbytes == '0 ? '0 : NW'(LANE_BYTES));
        fire        = in_valid && in_ready;
        cnt         = fill_q + CW'(nb);
        done        = fire && (in_last || (nb != '0 && cnt == CW'(BLOCK_BYTES)));
        pkcs_full   = pad_mode && cnt == CW'(BLOCK_BYTES);
        pad         = pad_mode ? 8'(CW'(BLOCK_BYTES) - cnt) : 8'h00;
        padblk_load = state_q == HOLD && out_ready && pend_q;
        blk         = '0;
        msk         = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            merged[i] = acc_q[i];
            for (int j = 0; j < LANE_BYTES; j++)
                if (fill_q + CW'(j) == CW'(i)) merged[i] = in_data[8*(LANE_BYTES-j)-1 -: 8];
            msk[i]                        = CW'(i) < cnt;
            blk[8*(BLOCK_BYTES-i)-1 -: 8] = msk[i] ? merged[i] : pad;
        end
        fill_d  = done ? '0 : (fire && nb != '0) ? fill_q + CW'(LANE_BYTES) : fill_q;
        pend_d  = done ? in_last && pkcs_full : (state_q == PADBLK && out_ready) ? 1'b0 : pend_q;
        data_d  = done ? blk : padblk_load ? {BLOCK_BYTES{8'(BLOCK_BYTES)}} : data_q;
        mask_d  = done ? msk : padblk_load ? '0 : mask_q;
        count_d = done ? cnt : padblk_load ? '0 : count_q;
        last_d  = done ? in_last && !pkcs_full : padblk_load ? 1'b1 : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Stale bytes are harmless: everything at or above the count is replaced by padding.
    always_ff @(posedge clk) begin
        if (fire) acc_q <= merged;
    end

    assign out_data  = data_q;
    assign out_mask  = mask_q;
    assign out_count = count_q;
    assign out_last  = last_q;
endmodule

// File: tb/tb_last_block_packer.sv
// tb_last_block_packer: directed messages against a message-level block model plus literal pins.
module tb_last_block_packer;
    localparam int B = 16;
    localparam int L = 4;

    typedef struct packed {
        logic [8*B-1:0] data;
        logic [B-1:0]   mask;
        logic [4:0]     count;
        logic           last;
    } blk_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_last, pad_mode, out_valid, out_ready, out_last;
    logic [8*L-1:0] in_data;
    logic [2:0]     in_nbytes;
    logic [8*B-1:0] out_data;
    logic [B-1:0]   out_mask;
    logic [4:0]     out_count;

    int   checks = 0;
    int   failures = 0;
    blk_t exp_q[$];
    blk_t got_q[$];
    logic [7:0] msg[$];

    last_block_packer #(.BLOCK_BYTES(B), .LANE_BYTES(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nbytes(in_nbytes), .in_last(in_last), .pad_mode(pad_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask), .out_count(out_count),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8*B-1:0] act, input logic [8*B-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Message-level model: blocks are successive B-byte chunks of the message, the last one padded.
    task automatic model(input bit mode);
        int n;
        int nblk;
        n    = msg.size();
        nblk = n == 0 ? 1 : (n + B - 1) / B;
        for (int b = 0; b < nblk; b++) begin
            blk_t e;
            int   cnt;
            cnt    = (n - b*B) > B ? B : n - b*B;
            e.data = '0;
            for (int i = 0; i < B; i++)
                e.data[8*(B-i)-1 -: 8] = i < cnt ? msg[b*B+i] : (mode ? 8'(B - cnt) : 8'h00);
            e.count = 5'(cnt);
            e.mask  = 16'((17'(1) << cnt) - 17'(1));
            e.last  = (b == nblk - 1) && !(mode && cnt == B);
            exp_q.push_back(e);
            if (b == nblk - 1 && mode && cnt == B) begin
                e.data  = {B{8'(B)}};
                e.count = '0;
                e.mask  = '0;
                e.last  = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic beat(input logic [8*L-1:0] d, input int nb, input bit last, input bit mode);
        int t;
        bit acc;
        t         = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = 3'(nb);
        in_last   = last;
        pad_mode  = mode;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        chk("beat_accept", acc, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {L{8'hEE}};
    endtask

    // Full lanes except the last; pad_mode flipped on non-last beats since it must be ignored there.
    task automatic send(input bit mode);
        int n;
        n = msg.size();
        model(mode);
        if (n == 0) beat({L{8'hEE}}, 0, 1'b1, mode);
        for (int k = 0; k < n; k += L) begin
            logic [8*L-1:0] d;
            for (int j = 0; j < L; j++) d[8*(L-j)-1 -: 8] = k + j < n ? msg[k+j] : 8'hEE;
            beat(d, (n - k) > L ? L : n - k, k + L >= n, (k + L >= n) ? mode : !mode);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic blk_t getb(input int k);
        blk_t z;
        z = '0;
        return k < got_q.size() ? got_q[k] : z;
    endfunction

    task automatic fill_msg(input logic [7:0] base, input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(base + 8'(i));
    endtask

    // Compare process: every output handshake is checked against the model, holds must be stable.
    bit   hold_prev = 1'b0;
    blk_t prev;
    always @(negedge clk) begin
        blk_t cur;
        blk_t e;
        cur = {out_data, out_mask, out_count, out_last};
        if (rst) hold_prev = 1'b0;
        else begin
            chk("in_ready_vs_out_valid", in_ready, !out_valid);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_stable", cur, prev);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                chk("block_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("blk_data", cur.data, e.data);
                    chk("blk_mask", cur.mask, e.mask);
                    chk("blk_count", cur.count, e.count);
                    chk("blk_last", cur.last, e.last);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev      = cur;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        in_last   = 1'b0;
        pad_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;

        fill_msg(8'h00, 16);
        got_q.delete();
        send(1'b0);
        chk("t1_latency", out_valid, 1);
        drain();
        chk("t1_nblk", got_q.size(), 1);
        chk("t1_data", getb(0).data, 128'h000102030405060708090a0b0c0d0e0f);
        chk("t1_mask", getb(0).mask, 16'hffff);
        chk("t1_count", getb(0).count, 16);
        chk("t1_last", getb(0).last, 1);

        fill_msg(8'h11, 5);
        got_q.delete();
        send(1'b1);
        drain();
        chk("t2_data", getb(0).data, 128'h11121314150b0b0b0b0b0b0b0b0b0b0b);
        chk("t2_mask", getb(0).mask, 16'h001f);
        chk("t2_count", getb(0).count, 5);
        chk("t2_last", getb(0).last, 1);

        fill_msg(8'h20, 16);
        got_q.delete();
        send(1'b1);
        drain();
        chk("t3_nblk", got_q.size(), 2);
        chk("t3_data_count", getb(0).count, 16);
        chk("t3_data_last", getb(0).last, 0);
        chk("t3_pad_data", getb(1).data, {16{8'h10}});
        chk("t3_pad_mask", getb(1).mask, 0);
        chk("t3_pad_count", getb(1).count, 0);
        chk("t3_pad_last", getb(1).last, 1);

        msg.delete();
        got_q.delete();
        send(1'b0);
        drain();
        send(1'b1);
        drain();
        chk("t4_zero_data", getb(0).data, 0);
        chk("t4_zero_count", getb(0).count, 0);
        chk("t4_zero_mask", getb(0).mask, 0);
        chk("t4_zero_last", getb(0).last, 1);
        chk("t4_pkcs_data", getb(1).data, {16{8'h10}});
        chk("t4_pkcs_last", getb(1).last, 1);

        fill_msg(8'h30, 20);
        got_q.delete();
        out_ready = 1'b0;
        fork
            send(1'b0);
            begin
                int t;
                t = 0;
                while (!out_valid && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("t5_first_valid", out_valid, 1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t5_nblk", got_q.size(), 2);
        chk("t5_first_data", getb(0).data, 128'h303132333435363738393a3b3c3d3e3f);
        chk("t5_second_count", getb(1).count, 4);
        chk("t5_second_mask", getb(1).mask, 16'h000f);
        chk("t5_second_data", getb(1).data, 128'h40414243000000000000000000000000);

        beat(32'h50515253, 4, 1'b0, 1'b0);
        beat(32'h54555657, 4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_data", out_data, 0);
        chk("t6_rst_out_mask", out_mask, 0);
        chk("t6_rst_out_count", out_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_msg(8'h61, 3);
        got_q.delete();
        send(1'b0);
        drain();
        chk("t6_count", getb(0).count, 3);
        chk("t6_mask", getb(0).mask, 16'h0007);
        chk("t6_data", getb(0).data, 128'h61626300000000000000000000000000);

        fill_msg(8'ha4, 8);
        got_q.delete();
        model(1'b0);
        beat(32'ha0a1a2a3, 0, 1'b0, 1'b1);
        beat(32'ha4a5a6a7, 2, 1'b0, 1'b1);
        beat(32'ha8a9aaab, 7, 1'b1, 1'b0);
        drain();
        chk("t7_count", getb(0).count, 8);
        chk("t7_data", getb(0).data, 128'ha4a5a6a7a8a9aaab0000000000000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
